// File: rtl/mux8_1.sv
// mux8_1 -- registered 8:1 multiplexer.
//
// On every rising clk edge, out loads the input chosen by selectors
// (000 -> in0 ... 111 -> in7), giving exactly one clock of latency.
// A high synchronous reset clears out to zero and takes priority over
// loading. The out register is the only state in the block.
//
// Ports:
//   out        output [WIDTH-1:0]  registered selected data
//   in0..in7   input  [WIDTH-1:0]  candidate data sources
//   selectors  input  [2:0]        binary source index
//   clk        input               clock, rising edge active
//   reset      input               synchronous, active-high clear of out
module mux8_1 #(
  parameter int unsigned WIDTH = 8
) (
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] in6,
  input  logic [WIDTH-1:0] in7,
  input  logic [2:0]       selectors,
  input  logic             clk,
  input  logic             reset
);

  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
    end else begin
      case (selectors)
        3'd0:    out <= in0;
        3'd1:    out <= in1;
        3'd2:    out <= in2;
        3'd3:    out <= in3;
        3'd4:    out <= in4;
        3'd5:    out <= in5;
        3'd6:    out <= in6;
        3'd7:    out <= in7;
        // Only an X/Z selector reaches here: propagate X rather than
        // silently falling back to a real input.
        default: out <= 'x;
      endcase
    end
  end

endmodule

// File: tb/tb_mux8_1.sv
// tb_mux8_1 -- scoreboard bench for mux8_1.
// Stimulus pushes the hand-computed (or reference-model) expected value of
// out for each rising edge; a monitor pops and compares on the falling edge.
module tb_mux8_1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit DUT signals
  logic [7:0] in_v [8];
  logic [2:0] selectors;
  logic       reset;
  logic [7:0] out;

  // 16-bit DUT signals
  logic [15:0] w_in [8];
  logic [2:0]  w_sel;
  logic        w_reset;
  logic [15:0] w_out;

  mux8_1 dut (
    .out(out), .in0(in_v[0]), .in1(in_v[1]), .in2(in_v[2]), .in3(in_v[3]),
    .in4(in_v[4]), .in5(in_v[5]), .in6(in_v[6]), .in7(in_v[7]),
    .selectors(selectors), .clk(clk), .reset(reset)
  );

  mux8_1 #(.WIDTH(16)) dut16 (
    .out(w_out), .in0(w_in[0]), .in1(w_in[1]), .in2(w_in[2]), .in3(w_in[3]),
    .in4(w_in[4]), .in5(w_in[5]), .in6(w_in[6]), .in7(w_in[7]),
    .selectors(w_sel), .clk(clk), .reset(w_reset)
  );

  logic [7:0]  exp_q   [$];
  string       tag_q   [$];
  logic [15:0] exp16_q [$];
  string       tag16_q [$];

  int errors = 0;
  int checks = 0;

  logic [7:0]  e8;
  logic [15:0] e16;
  string       t8, t16;

  // Monitor: one expected value per rising edge, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e8 = exp_q.pop_front();
      t8 = tag_q.pop_front();
      checks++;
      if (out !== e8) begin
        errors++;
        $display("FAIL %s: out=%h expected=%h at %0t", t8, out, e8, $time);
      end
    end
    if (exp16_q.size() > 0) begin
      e16 = exp16_q.pop_front();
      t16 = tag16_q.pop_front();
      checks++;
      if (w_out !== e16) begin
        errors++;
        $display("FAIL %s: out=%h expected=%h at %0t", t16, w_out, e16, $time);
      end
    end
  end

  // Apply reset/selectors now, let one rising edge sample them, record
  // the expected result of that edge, then step off the edge.
  task automatic step(input logic r, input logic [2:0] s,
                      input logic [7:0] exp, input string tag);
    reset     = r;
    selectors = s;
    @(posedge clk);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    #1;
  endtask

  task automatic step16(input logic r, input logic [2:0] s,
                        input logic [15:0] exp, input string tag);
    w_reset = r;
    w_sel   = s;
    @(posedge clk);
    exp16_q.push_back(exp);
    tag16_q.push_back(tag);
    #1;
  endtask

  task automatic load_base();
    in_v[0] = 8'hAA; in_v[1] = 8'h0F; in_v[2] = 8'hF0; in_v[3] = 8'h55;
    in_v[4] = 8'hE3; in_v[5] = 8'h33; in_v[6] = 8'hCC; in_v[7] = 8'h1C;
  endtask

  logic [7:0] v2_exp [8];
  logic       r_rand;
  logic [2:0] s_rand;

  initial begin
    v2_exp[0] = 8'hAA; v2_exp[1] = 8'h0F; v2_exp[2] = 8'hF0; v2_exp[3] = 8'h55;
    v2_exp[4] = 8'hE3; v2_exp[5] = 8'h33; v2_exp[6] = 8'hCC; v2_exp[7] = 8'h1C;

    load_base();
    reset     = 1'b0;
    selectors = 3'b011;
    w_reset   = 1'b1;
    w_sel     = 3'b000;
    for (int i = 0; i < 8; i++) w_in[i] = 16'h0000;
    @(posedge clk);
    #1;

    // V-1: reset held two clocks, then release
    step(1'b1, 3'b011, 8'h00, "v1_reset_a");
    step(1'b1, 3'b011, 8'h00, "v1_reset_b");
    step(1'b0, 3'b011, 8'h55, "v1_release");

    // V-2: sweep every selector code, 10 clocks each
    for (int s = 0; s < 8; s++)
      for (int k = 0; k < 10; k++)
        step(1'b0, 3'(s), v2_exp[s], $sformatf("v2_sel%0d", s));

    // V-3: selected and unselected input change in the same cycle
    step(1'b0, 3'b101, 8'h33, "v3_before");
    in_v[5] = 8'h7E;
    in_v[4] = 8'h00;
    step(1'b0, 3'b101, 8'h7E, "v3_sel_change");
    step(1'b0, 3'b101, 8'h7E, "v3_hold");
    in_v[4] = 8'hFF;
    step(1'b0, 3'b101, 8'h7E, "v3_unsel_only");
    // selector and newly selected input change together
    in_v[2] = 8'h96;
    step(1'b0, 3'b010, 8'h96, "v3_sel_and_data");
    // mid-cycle glitch on the selected input; only the edge value counts
    in_v[2] = 8'h01;
    #2;
    in_v[2] = 8'h3C;
    step(1'b0, 3'b010, 8'h3C, "v3_glitch");
    load_base();

    // V-4: reset wins over data at the same edge, then load
    step(1'b1, 3'b110, 8'h00, "v4_reset");
    step(1'b0, 3'b110, 8'hCC, "v4_release");
    // reset mid-operation clears in one edge, load resumes right after
    step(1'b0, 3'b000, 8'hAA, "v4_run");
    step(1'b1, 3'b000, 8'h00, "v4_mid_reset");
    step(1'b0, 3'b111, 8'h1C, "v4_resume");

    // V-5: random data/selector with ~5% reset, reference model
    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < 8; i++) in_v[i] = 8'($urandom);
      r_rand = ($urandom_range(0, 99) < 5);
      s_rand = 3'($urandom_range(0, 7));
      step(r_rand, s_rand, r_rand ? 8'h00 : in_v[s_rand], "v5_random");
    end

    // V-6: WIDTH=16 instance
    w_in[7] = 16'hBEEF;
    w_in[0] = 16'h1234;
    step16(1'b1, 3'b111, 16'h0000, "v6_reset");
    step16(1'b0, 3'b111, 16'hBEEF, "v6_sel7");
    step16(1'b0, 3'b000, 16'h1234, "v6_sel0");

    // drain the scoreboard with a bounded wait
    for (int w = 0; w < 10 && (exp_q.size() > 0 || exp16_q.size() > 0); w++)
      @(posedge clk);
    #6;
    if (exp_q.size() > 0 || exp16_q.size() > 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size() + exp16_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
